// File: rtl/md_sched.sv
// md_sched: multiply/divide sequencer beside the E-stage ALU.
// Owns the architectural HI/LO registers. It models the multi-cycle
// latency of mult/multu/div/divu with a busy down-counter, and it
// produces the D-stage stall term.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high
//   E_md_op     E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu,
//               5 mthi, 6 mtlo, 7 reserved (treated as none)
//   E_A, E_B    forwarded rs/rt values in E
//   E_hilo_sel  read select for E_hilo_out: 0 = LO, 1 = HI
//   D_is_md     the D-stage instruction is an MDU instruction
//   busy        a multiply/divide is in flight (FSM is in RUN)
//   md_stall    combinational stall request for D
//   E_hilo_out  combinational HI/LO read for mfhi/mflo in E
//   HI, LO      architectural registers
//
// Handshake: there is no ready/valid pair. An op is accepted only when
// busy is low. While busy is high, any op presented is dropped, and the
// pipeline relies on md_stall to keep MDU ops out of E during that time.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_hilo_sel,
  input  logic        D_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] E_hilo_out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  logic        is_mul;
  logic        is_div;
  logic        is_start;
  logic        is_signed;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] prod;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] div_den;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] nxt_hi;
  logic [31:0] nxt_lo;

  assign is_mul    = (E_md_op == 3'd1) || (E_md_op == 3'd2);
  assign is_div    = (E_md_op == 3'd3) || (E_md_op == 3'd4);
  assign is_start  = is_mul || is_div;
  assign is_signed = (E_md_op == 3'd1) || (E_md_op == 3'd3);

  // Result datapath. Signed division is done on magnitudes and the signs
  // are fixed up afterwards. This gives truncation toward zero, and it also
  // makes 0x80000000 / -1 wrap to 0x80000000 with remainder 0.
  always_comb begin
    mul_a   = is_signed ? {{32{E_A[31]}}, E_A} : {32'd0, E_A};
    mul_b   = is_signed ? {{32{E_B[31]}}, E_B} : {32'd0, E_B};
    prod    = mul_a * mul_b;
    a_mag   = (is_signed && E_A[31]) ? (32'd0 - E_A) : E_A;
    b_mag   = (is_signed && E_B[31]) ? (32'd0 - E_B) : E_B;
    // Keep the divider defined for a zero divisor; that result is discarded.
    div_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
    uq      = a_mag / div_den;
    ur      = a_mag % div_den;
    quo     = (is_signed && (E_A[31] ^ E_B[31])) ? (32'd0 - uq) : uq;
    rem     = (is_signed && E_A[31]) ? (32'd0 - ur) : ur;
    // Divide by zero captures the current HI/LO. Write-back then leaves
    // them unchanged, and nothing can modify HI/LO while in RUN.
    nxt_hi  = HI;
    nxt_lo  = LO;
    if (is_mul) begin
      nxt_hi = prod[63:32];
      nxt_lo = prod[31:0];
    end else if (is_div && (E_B != 32'd0)) begin
      nxt_hi = rem;
      nxt_lo = quo;
    end
  end

  assign busy       = (state == RUN);
  assign md_stall   = D_is_md & (busy | is_start);
  assign E_hilo_out = E_hilo_sel ? HI : LO;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_start) begin
            res_hi <= nxt_hi;
            res_lo <= nxt_lo;
            cnt    <= is_mul ? MULT_LOAD : DIV_LOAD;
            state  <= RUN;
          end else if (E_md_op == 3'd5) begin
            HI <= E_A;
          end else if (E_md_op == 3'd6) begin
            LO <= E_A;
          end
        end
        RUN: begin
          if (cnt == 4'd0) begin
            HI    <= res_hi;
            LO    <= res_lo;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched. Inputs are driven 1 time unit after the
// rising edge, and outputs are sampled 1 unit after that.
module tb_md_sched;

  logic        clk;
  logic        reset;
  logic [2:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_hilo_sel;
  logic        D_is_md;
  logic        busy;
  logic        md_stall;
  logic [31:0] E_hilo_out;
  logic [31:0] HI;
  logic [31:0] LO;

  int n_tests = 0;
  int n_fail  = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_md_op    (E_md_op),
    .E_A        (E_A),
    .E_B        (E_B),
    .E_hilo_sel (E_hilo_sel),
    .D_is_md    (D_is_md),
    .busy       (busy),
    .md_stall   (md_stall),
    .E_hilo_out (E_hilo_out),
    .HI         (HI),
    .LO         (LO)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a start op for one cycle. Then check N busy cycles and the
  // completion cycle. When inj is set, an mthi of 0xAAAA is presented in
  // the third busy cycle; it must be dropped.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic dmd, input logic inj,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    logic [31:0] hi0;
    logic [31:0] lo0;
    hi0 = HI;
    lo0 = LO;
    D_is_md = dmd;
    E_md_op = op;
    E_A = a;
    E_B = b;
    #1;
    chk({tag, "_start_stall"}, {31'd0, md_stall}, {31'd0, dmd});
    step();
    for (int i = 0; i < n; i++) begin
      if (inj && i == 2) begin
        E_md_op = 3'd5;
        E_A = 32'h0000AAAA;
      end else begin
        E_md_op = 3'd0;
      end
      #1;
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      chk({tag, "_run_stall"}, {31'd0, md_stall}, {31'd0, dmd});
      chk({tag, "_hi_hold"}, HI, hi0);
      chk({tag, "_lo_hold"}, LO, lo0);
      step();
    end
    E_md_op = 3'd0;
    #1;
    chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done_stall"}, {31'd0, md_stall}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask

  initial begin
    reset = 1'b1;
    E_md_op = 3'd0;
    E_A = 32'd0;
    E_B = 32'd0;
    E_hilo_sel = 1'b0;
    D_is_md = 1'b0;
    step();
    step();
    reset = 1'b0;
    D_is_md = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_stall", {31'd0, md_stall}, 32'd0);
    step();

    // mult -2 * 3 = -6
    run_op("mult", 3'd1, 32'hFFFFFFFE, 32'd3, 5, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA);
    // div -7 / 2 = -3 rem -1
    run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 10, 1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
    // overflow case
    run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0, 32'h0, 32'h80000000);

    // mthi / mtlo preload, then divu by zero
    E_md_op = 3'd5;
    E_A = 32'h1234;
    step();
    chk("mthi_hi", HI, 32'h1234);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    E_md_op = 3'd6;
    E_A = 32'h5678;
    step();
    chk("mtlo_lo", LO, 32'h5678);
    chk("mtlo_hi", HI, 32'h1234);
    run_op("divu0", 3'd4, 32'd100, 32'd0, 10, 1'b0, 1'b0, 32'h1234, 32'h5678);

    // multu with D_is_md held: stall on start plus all busy cycles
    run_op("multu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b1, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    D_is_md = 1'b0;
    E_hilo_sel = 1'b1;
    #1;
    chk("hilo_out_hi", E_hilo_out, 32'hFFFFFFFE);
    E_hilo_sel = 1'b0;
    #1;
    chk("hilo_out_lo", E_hilo_out, 32'h00000001);
    step();

    // mthi during RUN is ignored: 0x10000 * 0x30000 = 0x3_0000_0000
    run_op("ign", 3'd1, 32'h00010000, 32'h00030000, 5, 1'b1, 1'b1, 32'h3, 32'h0);
    D_is_md = 1'b0;
    step();

    // reset during a divide
    E_md_op = 3'd3;
    E_A = 32'd100;
    E_B = 32'd7;
    step();
    E_md_op = 3'd0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_hi", HI, 32'd0);
    chk("mid_rst_lo", LO, 32'd0);
    for (int i = 0; i < 8; i++) step();
    chk("late_busy", {31'd0, busy}, 32'd0);
    chk("late_hi", HI, 32'd0);
    chk("late_lo", LO, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
